// File: rtl/bus_mux_reg.sv
// Registered shared-bus multiplexer: fixed-priority source select, one-cycle latency,
// with conflict pulse, sticky flag and saturating conflict counter.
module bus_mux_reg #(
    parameter int DATA_W    = 32,
    parameter int N_SRC     = 24,
    parameter int SEL_W     = 5,
    parameter int CNT_W     = 8,
    parameter bit IDLE_ZERO = 1'b0
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_oe,
    input  logic                    err_clr,
    output logic [DATA_W-1:0]       bus_out,
    output logic                    bus_valid,
    output logic [SEL_W-1:0]        bus_src,
    output logic                    conflict,
    output logic                    conflict_sticky,
    output logic [CNT_W-1:0]        conflict_cnt
);

    localparam logic [CNT_W-1:0] cntMax = '1;

    logic [SEL_W-1:0]  selIdx;
    logic [DATA_W-1:0] selData;
    logic              anyOe;
    logic              multiOe;

    // Descending scan so the lowest set index is the last (winning) assignment.
    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise an
        // unassigned path would infer a latch.
        selIdx  = '0;
        selData = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_oe[i]) begin
                selIdx  = SEL_W'(i);
                selData = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Two or more enables: a second set bit after any earlier one.
    always_comb begin
        anyOe   = 1'b0;
        multiOe = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            multiOe = multiOe | (anyOe & src_oe[i]);
            anyOe   = anyOe | src_oe[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            bus_out         <= '0;
            bus_valid       <= 1'b0;
            bus_src         <= '0;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else begin
            if (anyOe) begin
                bus_out   <= selData;
                bus_src   <= selIdx;
                bus_valid <= 1'b1;
            end else begin
                bus_valid <= 1'b0;
                if (IDLE_ZERO) begin
                    bus_out <= '0;
                end
            end

            conflict <= multiOe;

            // A conflict in the same cycle as err_clr restarts the count at one.
            if (multiOe) begin
                conflict_sticky <= 1'b1;
                if (err_clr) begin
                    conflict_cnt <= CNT_W'(1);
                end else if (conflict_cnt != cntMax) begin
                    conflict_cnt <= conflict_cnt + CNT_W'(1);
                end
            end else if (err_clr) begin
                conflict_sticky <= 1'b0;
                conflict_cnt    <= '0;
            end
        end
    end

endmodule
